// File: rtl/udma_eth_rx_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : udma_eth_rx_packer_if
// Brief    : Byte stream in from the MAC RX FIFO and 32-bit word stream out
//            to the uDMA RX channel.
// Revision : 1.0 - initial release
// ============================================================================
interface udma_eth_rx_packer_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [31:0] data_rx_o;
  logic        data_rx_valid_o;
  logic        data_rx_ready_i;
  logic [1:0]  data_rx_datasize_o;

  // The packer sits on the slave side of the byte stream
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output data_rx_o, data_rx_valid_o, data_rx_datasize_o,
    input  data_rx_ready_i
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  data_rx_o, data_rx_valid_o, data_rx_datasize_o,
    output data_rx_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/udma_eth_rx_packer.sv
`default_nettype none
// ============================================================================
// Module   : udma_eth_rx_packer
// Brief    : Packs RX bytes little-endian into 32-bit uDMA words and appends a
//            length/error trailer word after each frame.
// Revision : 1.0 - initial release
// ============================================================================
module udma_eth_rx_packer #(
  parameter int MAX_FRAME      = 1522,
  parameter int LEN_WIDTH      = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_en_i,
  udma_eth_rx_packer_if.slave       bus,
  output logic                      frame_done_o,
  output logic                      frame_err_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  localparam logic [31:0] c_max   = 32'(MAX_FRAME);
  localparam logic [31:0] c_limit = 32'(MAX_FRAME - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 r_run;
  logic [23:0]          r_acc;
  logic [1:0]           r_lane;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_bad;
  logic                 r_trunc;
  logic                 r_trl_loaded;
  logic [31:0]          r_data;
  logic                 r_valid;
  logic                 r_err;
  logic [DROP_CNT_WIDTH-1:0] r_drop;

  logic        w_slot_free;
  logic        w_tready;
  logic        w_accept;
  logic        w_pack;
  logic        w_drop_inc;
  logic        w_trl_load;
  logic        w_trl_done;
  logic        w_below;
  logic        w_flush;
  logic [31:0] w_word;
  logic [31:0] w_len32;

  assign w_slot_free = !r_valid || bus.data_rx_ready_i;
  assign w_len32     = 32'(r_len);
  assign w_below     = w_len32 < c_max;
  // The word also closes at the length limit so a partially filled word is not stranded
  assign w_flush     = w_below && ((r_lane == 2'd3) || bus.s_axis_tlast || (w_len32 == c_limit));

  always_comb begin
    w_word = 32'd0;
    case (r_lane)
      2'd0:    w_word = {24'd0, bus.s_axis_tdata};
      2'd1:    w_word = {16'd0, bus.s_axis_tdata, r_acc[7:0]};
      2'd2:    w_word = {8'd0,  bus.s_axis_tdata, r_acc[15:0]};
      default: w_word = {bus.s_axis_tdata, r_acc[23:0]};
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cfg_en_i) w_state_nxt = bus.s_axis_tlast ? ST_TRAIL : ST_RECV;
          else          w_state_nxt = bus.s_axis_tlast ? ST_IDLE  : ST_DROP;
        end
      end
      ST_RECV:  if (w_accept && bus.s_axis_tlast) w_state_nxt = ST_TRAIL;
      ST_DROP:  if (w_accept && bus.s_axis_tlast) w_state_nxt = ST_IDLE;
      ST_TRAIL: if (w_trl_done)                   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tready   = 1'b0;
    w_trl_load = 1'b0;
    w_trl_done = 1'b0;
    case (r_state)
      ST_IDLE:  w_tready = cfg_en_i ? w_slot_free : 1'b1;
      ST_RECV:  w_tready = w_slot_free;
      ST_DROP:  w_tready = 1'b1;
      ST_TRAIL: begin
        w_trl_load = !r_trl_loaded && w_slot_free;
        w_trl_done = r_trl_loaded && r_valid && bus.data_rx_ready_i;
      end
      default:  w_tready = 1'b0;
    endcase
    w_tready   = w_tready && r_run;
    w_accept   = bus.s_axis_tvalid && w_tready;
    w_pack     = w_accept && ((r_state == ST_RECV) || ((r_state == ST_IDLE) && cfg_en_i));
    w_drop_inc = w_accept && bus.s_axis_tlast &&
                 ((r_state == ST_DROP) || ((r_state == ST_IDLE) && !cfg_en_i));
  end

  // Holds tready low while reset is asserted and for the first cycle after
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_run <= 1'b0;
    else         r_run <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc        <= '0;
      r_lane       <= '0;
      r_len        <= '0;
      r_bad        <= 1'b0;
      r_trunc      <= 1'b0;
      r_trl_loaded <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_drop       <= '0;
    end else begin
      if (w_pack) begin
        if (r_len != {LEN_WIDTH{1'b1}}) r_len <= r_len + 1'b1;
        if (w_below) begin
          r_acc  <= w_word[23:0];
          r_lane <= w_flush ? 2'd0 : r_lane + 2'd1;
        end else begin
          r_trunc <= 1'b1;
        end
        if (bus.s_axis_tlast) r_bad <= bus.s_axis_tuser;
      end

      if (w_pack && w_flush) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_trl_load) begin
        r_data       <= {r_bad, r_trunc, {(30-LEN_WIDTH){1'b0}}, r_len};
        r_valid      <= 1'b1;
        r_trl_loaded <= 1'b1;
      end else if (bus.data_rx_ready_i) begin
        r_valid <= 1'b0;
      end

      if (w_trl_done) begin
        r_err        <= r_bad | r_trunc;
        r_len        <= '0;
        r_lane       <= '0;
        r_bad        <= 1'b0;
        r_trunc      <= 1'b0;
        r_trl_loaded <= 1'b0;
      end

      if (w_drop_inc && (r_drop != {DROP_CNT_WIDTH{1'b1}})) r_drop <= r_drop + 1'b1;
    end
  end

  assign bus.s_axis_tready      = w_tready;
  assign bus.data_rx_o          = r_data;
  assign bus.data_rx_valid_o    = r_valid;
  assign bus.data_rx_datasize_o = 2'b10;
  assign frame_done_o           = w_trl_done;
  assign frame_err_o            = r_err;
  assign drop_cnt_o             = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_udma_eth_rx_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_udma_eth_rx_packer
// Brief    : Random and directed frames on two packer instances (full-size and
//            8-byte limit) checked against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udma_eth_rx_packer;

  typedef struct packed {
    logic [31:0] word;
    logic        trl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic cfg_en;
  logic done_a, done_b, err_a, err_b;
  logic [7:0] drop_a, drop_b;

  udma_eth_rx_packer_if ifa();
  udma_eth_rx_packer_if ifb();

  udma_eth_rx_packer #(.MAX_FRAME(1522), .LEN_WIDTH(16), .DROP_CNT_WIDTH(8)) u_dut_a (
    .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .bus(ifa.slave),
    .frame_done_o(done_a), .frame_err_o(err_a), .drop_cnt_o(drop_a)
  );

  udma_eth_rx_packer #(.MAX_FRAME(8), .LEN_WIDTH(16), .DROP_CNT_WIDTH(8)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .cfg_en_i(cfg_en), .bus(ifb.slave),
    .frame_done_o(done_b), .frame_err_o(err_b), .drop_cnt_o(drop_b)
  );

  logic [31:0] m_data[2];
  logic        m_valid[2], m_ready[2], m_done[2], m_err[2], m_tready[2];
  logic [7:0]  m_drop[2];
  assign m_data[0] = ifa.data_rx_o;        assign m_data[1] = ifb.data_rx_o;
  assign m_valid[0] = ifa.data_rx_valid_o; assign m_valid[1] = ifb.data_rx_valid_o;
  assign m_ready[0] = ifa.data_rx_ready_i; assign m_ready[1] = ifb.data_rx_ready_i;
  assign m_tready[0] = ifa.s_axis_tready;  assign m_tready[1] = ifb.s_axis_tready;
  assign m_done[0] = done_a;               assign m_done[1] = done_b;
  assign m_err[0] = err_a;                 assign m_err[1] = err_b;
  assign m_drop[0] = drop_a;               assign m_drop[1] = drop_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t expq[2][$];
  int   exp_drop[2];
  logic exp_err[2];
  int   rdy_mode[2];
  logic prev_stall[2];
  logic [31:0] prev_data[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output-side monitor: every consumed word is popped against the model
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        exp_t e;
        if (prev_stall[s]) begin
          check_eq("hold_valid", 32'(m_valid[s]), 32'd1);
          check_eq("hold_data", m_data[s], prev_data[s]);
        end
        if (m_valid[s] && m_ready[s]) begin
          check_eq("word_expected", 32'(expq[s].size() != 0), 32'd1);
          if (expq[s].size() != 0) begin
            e = expq[s].pop_front();
            check_eq(s == 0 ? "a_word" : "b_word", m_data[s], e.word);
            check_eq("frame_done", 32'(m_done[s]), 32'(e.trl));
          end
        end else begin
          check_eq("frame_done_idle", 32'(m_done[s]), 32'd0);
        end
        prev_stall[s] = m_valid[s] && !m_ready[s];
        prev_data[s]  = m_data[s];
      end
    end
  end

  initial begin
    logic t;
    t = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      t = ~t;
      for (int s = 0; s < 2; s++) begin
        logic r;
        case (rdy_mode[s])
          0:       r = 1'b1;
          1:       r = t;
          default: r = 1'($urandom_range(0, 1));
        endcase
        if (s == 0) ifa.data_rx_ready_i = r;
        else        ifb.data_rx_ready_i = r;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_byte(input int sel, input logic v, input logic [7:0] d, input logic l, input logic u);
    if (sel == 0) begin
      ifa.s_axis_tvalid = v; ifa.s_axis_tdata = d; ifa.s_axis_tlast = l; ifa.s_axis_tuser = u;
    end else begin
      ifb.s_axis_tvalid = v; ifb.s_axis_tdata = d; ifb.s_axis_tlast = l; ifb.s_axis_tuser = u;
    end
  endtask

  task automatic push_byte(input int sel, input logic [7:0] d, input logic l, input logic u, output logic ok);
    int t;
    ok = 1'b0;
    t  = 0;
    drive_byte(sel, 1'b1, d, l, u);
    while (!ok && t < 500) begin
      @(negedge clk);
      ok = m_tready[sel];
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("byte_accept", 32'(ok), 32'd1);
    drive_byte(sel, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Reference: frame in, list of expected uDMA words out
  task automatic model_frame(input int sel, input logic [7:0] b[$], input logic user, input logic en);
    int n, maxf, wr;
    logic [31:0] w;
    n = b.size();
    if (!en) begin
      if (exp_drop[sel] < 255) exp_drop[sel]++;
    end else begin
      maxf = (sel == 0) ? 1522 : 8;
      wr   = (n < maxf) ? n : maxf;
      for (int i = 0; i < wr; i += 4) begin
        w = 32'd0;
        for (int k = 0; k < 4; k++)
          if (i + k < wr) w = w | (32'(b[i+k]) << (8 * k));
        expq[sel].push_back('{word: w, trl: 1'b0});
      end
      w = {user, 1'(n > maxf), 14'd0, 16'(n)};
      expq[sel].push_back('{word: w, trl: 1'b1});
      exp_err[sel] = user | (n > maxf);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] b[$], input logic user,
                            input logic en, input logic flip_en, input int max_gap);
    logic ok;
    int   n;
    n = b.size();
    model_frame(sel, b, user, en);
    cfg_en = en;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      push_byte(sel, b[i], 1'(i == n - 1), (i == n - 1) ? user : 1'($urandom_range(0, 1)), ok);
      if (!ok) return;
      if (i == 0 && flip_en) cfg_en = ~en;
    end
  endtask

  task automatic drain(input int sel);
    int t;
    t = 0;
    while (expq[sel].size() != 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("drain", 32'(expq[sel].size()), 32'd0);
    @(posedge clk);
    #1;
    check_eq("frame_err", 32'(m_err[sel]), 32'(exp_err[sel]));
    check_eq("drop_cnt", 32'(m_drop[sel]), 32'(exp_drop[sel]));
  endtask

  task automatic make_frame(input int n, input logic [7:0] start, input logic rnd, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++)
      q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(start + 8'(i)));
  endtask

  initial begin
    logic [7:0] fb[$];
    logic ok;
    int sel;

    rstn = 1'b0;
    cfg_en = 1'b0;
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    for (int s = 0; s < 2; s++) begin
      exp_drop[s] = 0;
      exp_err[s]  = 1'b0;
      prev_stall[s] = 1'b0;
    end
    drive_byte(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive_byte(1, 1'b0, 8'h00, 1'b0, 1'b0);
    ifa.s_axis_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", ifa.data_rx_o, 32'd0);
    check_eq("rst_valid", 32'(ifa.data_rx_valid_o), 32'd0);
    check_eq("rst_tready", 32'(ifa.s_axis_tready), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);
    check_eq("rst_drop", 32'(drop_a), 32'd0);
    check_eq("datasize", 32'(ifa.data_rx_datasize_o), 32'd2);
    ifa.s_axis_tvalid = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    make_frame(6, 8'h01, 1'b0, fb);
    send_frame(0, fb, 1'b0, 1'b1, 1'b0, 0);
    drain(0);

    make_frame(20, 8'h30, 1'b0, fb);
    send_frame(0, fb, 1'b0, 1'b0, 1'b0, 0);
    send_frame(0, fb, 1'b0, 1'b0, 1'b1, 1);
    make_frame(9, 8'h50, 1'b0, fb);
    send_frame(0, fb, 1'b0, 1'b1, 1'b0, 0);
    drain(0);

    fb.delete();
    fb.push_back(8'hAA);
    send_frame(0, fb, 1'b1, 1'b1, 1'b0, 0);
    drain(0);

    // Reset lands after the third byte of an unfinished frame
    cfg_en = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(0, 8'h10 + 8'(i), 1'b0, 1'b0, ok);
    drive_byte(0, 1'b1, 8'h13, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(ifa.data_rx_valid_o), 32'd0);
    check_eq("mid_rst_data", ifa.data_rx_o, 32'd0);
    check_eq("mid_rst_tready", 32'(ifa.s_axis_tready), 32'd0);
    check_eq("mid_rst_err", 32'(err_a), 32'd0);
    check_eq("mid_rst_drop", 32'(drop_a), 32'd0);
    drive_byte(0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      expq[s].delete();
      exp_drop[s] = 0;
      exp_err[s]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    make_frame(7, 8'hC1, 1'b0, fb);
    send_frame(0, fb, 1'b0, 1'b1, 1'b0, 0);
    drain(0);

    rdy_mode[0] = 1;
    make_frame(64, 8'h00, 1'b0, fb);
    send_frame(0, fb, 1'b0, 1'b1, 1'b0, 0);
    drain(0);

    make_frame(11, 8'h01, 1'b0, fb);
    send_frame(1, fb, 1'b0, 1'b1, 1'b0, 0);
    drain(1);
    make_frame(8, 8'h21, 1'b0, fb);
    send_frame(1, fb, 1'b1, 1'b1, 1'b0, 0);
    drain(1);

    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 1));
      rdy_mode[0] = int'($urandom_range(0, 2));
      rdy_mode[1] = int'($urandom_range(0, 2));
      make_frame(int'($urandom_range(1, 70)), 8'h00, 1'b1, fb);
      send_frame(sel, fb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 1)), 2);
      if ($urandom_range(0, 2) == 0) drain(sel);
    end
    drain(0);
    drain(1);

    rdy_mode[0] = 2;
    for (int f = 0; f < 260; f++) begin
      make_frame(int'($urandom_range(1, 3)), 8'h00, 1'b1, fb);
      send_frame(0, fb, 1'b0, 1'b0, 1'b0, 0);
    end
    drain(0);
    check_eq("drop_sat", 32'(drop_a), 32'hFF);

    make_frame(5, 8'hE0, 1'b0, fb);
    send_frame(0, fb, 1'b0, 1'b1, 1'b0, 1);
    drain(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
